ram_arbiter: RTL

- Two-master arbiter that shares the single-port synchronous data RAM (14-bit address, 16-bit data, registered q) between requester m0 and requester m1.
- m0 is typically the CPU-side bus bridge; m1 is an auxiliary master such as a program loader or display scanout.
- Serialises accesses through a 3-state FSM, drives the RAM address/data/wren ports from registers, and returns read data plus a one-cycle ack to the winning master.

---
 rtl/ram_arbiter_pkg.sv | 17 +
 rtl/rr_pick2.sv | 22 ++
 rtl/ram_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-master data RAM arbiter.
// Also used by rr_pick2 consumers elsewhere on the peripheral bus.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2
  } arbState_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_DATA_W = 16;

endpackage

// File: rtl/rr_pick2.sv
// Two-input combinational picker: round-robin on ties, or fixed priority
// to req0 when mode is set.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic lastGnt,
  input  logic mode,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = mode ? 1'b0 : ~lastGnt;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two masters onto one single-port synchronous RAM with a
// registered q; each access takes IDLE -> ACCESS -> CAPTURE and ends in an ack.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ARB_MODE = ARB_RR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy,
  output logic              gnt_id
);

  localparam logic FIXED_MODE = 1'(ARB_MODE == ARB_FIXED);

  arbState_t state, nextState;
  logic      lastGnt;
  logic      opWrite;
  logic      mreq0, mreq1;
  logic      pickValid, pickWinner;

  // A master being acked this cycle is masked so it cannot retrigger while dropping req.
  assign mreq0 = m0_req & ~m0_ack;
  assign mreq1 = m1_req & ~m1_ack;

  rr_pick2 uPick (
    .req0   (mreq0),
    .req1   (mreq1),
    .lastGnt(lastGnt),
    .mode   (FIXED_MODE),
    .valid  (pickValid),
    .winner (pickWinner)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (pickValid) nextState = ACCESS;
      ACCESS:  nextState = CAPTURE;
      CAPTURE: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // opWrite remembers the access type because ram_wren is already cleared by CAPTURE.
  always_ff @(posedge clk) begin
    if (reset) begin
      ram_address <= '0;
      ram_data    <= '0;
      ram_wren    <= 1'b0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      gnt_id      <= 1'b0;
      lastGnt     <= 1'b1;
      opWrite     <= 1'b0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (pickValid) begin
            gnt_id      <= pickWinner;
            lastGnt     <= pickWinner;
            ram_address <= pickWinner ? m1_addr  : m0_addr;
            ram_data    <= pickWinner ? m1_wdata : m0_wdata;
            ram_wren    <= pickWinner ? m1_we    : m0_we;
            opWrite     <= pickWinner ? m1_we    : m0_we;
          end
        end
        ACCESS: ram_wren <= 1'b0;
        CAPTURE: begin
          if (gnt_id) begin
            m1_ack <= 1'b1;
            if (!opWrite) m1_rdata <= ram_q;
          end else begin
            m0_ack <= 1'b1;
            if (!opWrite) m0_rdata <= ram_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
